// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl_if
//  Purpose  : Bundles the MEM-stage request/response handshake and the
//             word-indexed Data_Memory port used by mem_access_ctrl.
//  Signals  :
//    req_valid/req_ready     load/store request handshake
//    req_store               1 = store, 0 = load
//    req_size                00 byte, 01 half, 10/11 word
//    req_unsigned            load zero-extends when 1
//    req_addr/req_wdata      byte address, right-justified store data
//    req_rd                  load destination tag
//    rsp_rvalid/rdata/rd     load result pulse
//    rsp_wdone               store committed pulse
//    err_misaligned/range    fault pulses, err_bad_addr = faulting address
//    mem_addr/wdata/enables  Data_Memory port, mem_rdata = memory read data
//  Modports : master = requester + memory model, slave = controller
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int RAM_WIDTH = 32,
    parameter int NB_DEPTH  = 10,
    parameter int NB_ADDR   = 32,
    parameter int NB_REG    = 5
);
    logic                 req_valid;
    logic                 req_store;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [NB_ADDR-1:0]   req_addr;
    logic [RAM_WIDTH-1:0] req_wdata;
    logic [NB_REG-1:0]    req_rd;
    logic                 req_ready;

    logic                 rsp_rvalid;
    logic [RAM_WIDTH-1:0] rsp_rdata;
    logic [NB_REG-1:0]    rsp_rd;
    logic                 rsp_wdone;
    logic                 err_misaligned;
    logic                 err_range;
    logic [NB_ADDR-1:0]   err_bad_addr;

    logic [NB_DEPTH-1:0]  mem_addr;
    logic [RAM_WIDTH-1:0] mem_wdata;
    logic [1:0]           mem_write_enable;
    logic [1:0]           mem_read_enable;
    logic [RAM_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr,
               req_wdata, req_rd, mem_rdata,
        input  req_ready, rsp_rvalid, rsp_rdata, rsp_rd, rsp_wdone,
               err_misaligned, err_range, err_bad_addr,
               mem_addr, mem_wdata, mem_write_enable, mem_read_enable
    );

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr,
               req_wdata, req_rd, mem_rdata,
        output req_ready, rsp_rvalid, rsp_rdata, rsp_rd, rsp_wdone,
               err_misaligned, err_range, err_bad_addr,
               mem_addr, mem_wdata, mem_write_enable, mem_read_enable
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage initiator for Data_Memory. Accepts one load/store per
//             handshake, converts byte addresses to word indices, shifts and
//             sign/zero-extends loads, performs read-modify-write for sub-word
//             stores that are not in lane 0, and flags misaligned or
//             out-of-range accesses.
//  Ports    :
//    clk     in   clock, all state on rising edge
//    rst     in   asynchronous reset, active high
//    bus     slave modport of mem_access_ctrl_if (request, response, faults,
//            Data_Memory port)
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int RAM_WIDTH = 32,
    parameter int NB_DEPTH  = 10,
    parameter int NB_ADDR   = 32,
    parameter int NB_REG    = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_ctrl_if.slave bus
);

    // Data_Memory enable encodings
    localparam logic [1:0] c_WRITE_DISABLE  = 2'b00;
    localparam logic [1:0] c_WRITE_BYTE     = 2'b01;
    localparam logic [1:0] c_WRITE_HALFWORD = 2'b10;
    localparam logic [1:0] c_WRITE_WORD     = 2'b11;
    localparam logic [1:0] c_READ_DISABLE   = 2'b00;
    localparam logic [1:0] c_READ_WORD      = 2'b11;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LD_RD   = 3'd1;
    localparam logic [2:0] c_LD_CAP  = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_RMW_RD  = 3'd4;
    localparam logic [2:0] c_RMW_CAP = 3'd5;
    localparam logic [2:0] c_RMW_WR  = 3'd6;
    localparam logic [2:0] c_ERR     = 3'd7;

    logic [2:0]           r_state;

    // request fields captured at accept
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [1:0]           r_off;
    logic [RAM_WIDTH-1:0] r_wdata;
    logic [NB_REG-1:0]    r_rd;
    logic [NB_ADDR-1:0]   r_addr;
    logic                 r_is_range;

    // registered outputs
    logic                 r_rvalid;
    logic [RAM_WIDTH-1:0] r_rdata;
    logic [NB_REG-1:0]    r_rd_out;
    logic                 r_wdone;
    logic                 r_misaligned;
    logic                 r_range_err;
    logic [NB_ADDR-1:0]   r_bad_addr;
    logic [NB_DEPTH-1:0]  r_mem_addr;
    logic [RAM_WIDTH-1:0] r_mem_wdata;
    logic [1:0]           r_mem_we;
    logic [1:0]           r_mem_re;

    logic                 w_range;
    logic                 w_misaligned;
    logic                 w_rmw;
    logic [RAM_WIDTH-1:0] w_shifted;
    logic [RAM_WIDTH-1:0] w_ld_ext;
    logic [RAM_WIDTH-1:0] w_merged;
    logic [1:0]           w_native_we;

    // Request classification (evaluated on the live request while IDLE)
    assign w_range      = |bus.req_addr[NB_ADDR-1:NB_DEPTH+2];
    assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                          (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    // Sub-word store outside lane 0: the memory only writes low lanes
    // natively, so the word must be read, merged and rewritten.
    assign w_rmw        = !bus.req_size[1] && (bus.req_addr[1:0] != 2'b00);

    // Load alignment and extension
    always_comb begin
        w_shifted = bus.mem_rdata >> {r_off, 3'b000};
        w_ld_ext  = w_shifted;
        case (r_size)
            2'b00: w_ld_ext = r_uns ? {{(RAM_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                    : {{(RAM_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_ld_ext = r_uns ? {{(RAM_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                    : {{(RAM_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_ext = w_shifted;
        endcase
    end

    // Lane merge for read-modify-write (half RMW only occurs at offset 2)
    always_comb begin
        w_merged = bus.mem_rdata;
        if (r_size == 2'b01) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            case (r_off)
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                2'b11:   w_merged[31:24] = r_wdata[7:0];
                default: w_merged        = bus.mem_rdata;
            endcase
        end
    end

    always_comb begin
        case (r_size)
            2'b00:   w_native_we = c_WRITE_BYTE;
            2'b01:   w_native_we = c_WRITE_HALFWORD;
            default: w_native_we = c_WRITE_WORD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_off        <= 2'b00;
            r_wdata      <= '0;
            r_rd         <= '0;
            r_addr       <= '0;
            r_is_range   <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rd_out     <= '0;
            r_wdone      <= 1'b0;
            r_misaligned <= 1'b0;
            r_range_err  <= 1'b0;
            r_bad_addr   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= c_WRITE_DISABLE;
            r_mem_re     <= c_READ_DISABLE;
        end else begin
            r_rvalid     <= 1'b0;
            r_wdone      <= 1'b0;
            r_misaligned <= 1'b0;
            r_range_err  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_size     <= bus.req_size;
                        r_uns      <= bus.req_unsigned;
                        r_off      <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        r_rd       <= bus.req_rd;
                        r_addr     <= bus.req_addr;
                        r_is_range <= w_range;
                        // range is checked before alignment
                        if (w_range || w_misaligned) begin
                            r_state <= c_ERR;
                        end else begin
                            r_mem_addr <= bus.req_addr[NB_DEPTH+1:2];
                            if (!bus.req_store)
                                r_state <= c_LD_RD;
                            else if (w_rmw)
                                r_state <= c_RMW_RD;
                            else
                                r_state <= c_ST_WR;
                        end
                    end
                end

                c_ERR: begin
                    r_range_err  <= r_is_range;
                    r_misaligned <= !r_is_range;
                    r_bad_addr   <= r_addr;
                    r_state      <= c_IDLE;
                end

                c_LD_RD: begin
                    r_mem_re <= c_READ_WORD;
                    r_state  <= c_LD_CAP;
                end

                // First cycle drops the read enable; memory data is valid
                // on the second cycle, which captures and returns it.
                c_LD_CAP: begin
                    if (r_mem_re != c_READ_DISABLE) begin
                        r_mem_re <= c_READ_DISABLE;
                    end else begin
                        r_rdata  <= w_ld_ext;
                        r_rd_out <= r_rd;
                        r_rvalid <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                end

                // Write enable raised for one cycle, then the store completes.
                c_ST_WR: begin
                    if (r_mem_we == c_WRITE_DISABLE) begin
                        r_mem_we    <= w_native_we;
                        r_mem_wdata <= r_wdata;
                    end else begin
                        r_mem_we <= c_WRITE_DISABLE;
                        r_wdone  <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                end

                c_RMW_RD: begin
                    r_mem_re <= c_READ_WORD;
                    r_state  <= c_RMW_CAP;
                end

                c_RMW_CAP: begin
                    if (r_mem_re != c_READ_DISABLE) begin
                        r_mem_re <= c_READ_DISABLE;
                    end else begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= c_WRITE_WORD;
                        r_state     <= c_RMW_WR;
                    end
                end

                c_RMW_WR: begin
                    r_mem_we <= c_WRITE_DISABLE;
                    r_wdone  <= 1'b1;
                    r_state  <= c_IDLE;
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.req_ready        = (r_state == c_IDLE);
    assign bus.rsp_rvalid       = r_rvalid;
    assign bus.rsp_rdata        = r_rdata;
    assign bus.rsp_rd           = r_rd_out;
    assign bus.rsp_wdone        = r_wdone;
    assign bus.err_misaligned   = r_misaligned;
    assign bus.err_range        = r_range_err;
    assign bus.err_bad_addr     = r_bad_addr;
    assign bus.mem_addr         = r_mem_addr;
    assign bus.mem_wdata        = r_mem_wdata;
    assign bus.mem_write_enable = r_mem_we;
    assign bus.mem_read_enable  = r_mem_re;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl with a word-indexed
//             Data_Memory model and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int RAM_WIDTH = 32;
    localparam int NB_DEPTH  = 10;
    localparam int NB_ADDR   = 32;
    localparam int NB_REG    = 5;

    localparam logic [1:0] WE_DIS = 2'b00;
    localparam logic [1:0] WE_B   = 2'b01;
    localparam logic [1:0] WE_H   = 2'b10;
    localparam logic [1:0] WE_W   = 2'b11;
    localparam logic [1:0] RE_DIS = 2'b00;
    localparam logic [1:0] RE_W   = 2'b11;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_MIS   = 2;
    localparam int K_RANGE = 3;

    typedef struct {
        bit          st;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          kind;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_ctrl_if #(
        .RAM_WIDTH(RAM_WIDTH), .NB_DEPTH(NB_DEPTH),
        .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)
    ) bus ();

    mem_access_ctrl #(
        .RAM_WIDTH(RAM_WIDTH), .NB_DEPTH(NB_DEPTH),
        .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #2.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data_Memory model: registered read, lane-0 based byte/half writes
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_read_enable == RE_W)
            bus.mem_rdata <= mem[bus.mem_addr];
        case (bus.mem_write_enable)
            WE_B:    mem[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
            WE_H:    mem[bus.mem_addr][15:0] <= bus.mem_wdata[15:0];
            WE_W:    mem[bus.mem_addr]       <= bus.mem_wdata;
            default: ;
        endcase
    end

    int   checks = 0;
    int   fails  = 0;
    int   exp_wr = 0;
    int   exp_rd = 0;
    int   wr_cyc = 0;
    int   rd_cyc = 0;
    exp_t sbq[$];
    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(bit st, logic [1:0] sz, bit uns, logic [31:0] a,
                                logic [31:0] wd, logic [4:0] rd, int kind,
                                logic [31:0] ex, int lat);
        vec_t v;
        v.st = st; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.rd = rd; v.kind = kind; v.exp = ex; v.lat = lat;
        return v;
    endfunction

    // Entered and left on a negedge; leaves with cyc == accept cycle k.
    task automatic do_req(input vec_t v, input bit push);
        int w;
        int kacc;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("ready_timeout", 32'(w), 32'd0);
        bus.req_valid    = 1'b1;
        bus.req_store    = v.st;
        bus.req_size     = v.sz;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_rd       = v.rd;
        @(negedge clk);
        kacc = cyc;
        // scramble inputs: the access in flight must not notice
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_rd       = 5'($urandom);
        if (push) begin
            sbq.push_back('{v.kind, v.exp, v.rd, kacc + v.lat});
            if (v.kind == K_LOAD) exp_rd++;
            if (v.kind == K_STORE) begin
                exp_wr++;
                if (v.lat == 4) exp_rd++;
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
    endtask

    // Response monitor / scoreboard
    initial begin
        int   npulse;
        int   kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_write_enable != WE_DIS) wr_cyc++;
            if (bus.mem_read_enable != RE_DIS) rd_cyc++;
            if (!rst) begin
                npulse = int'(bus.rsp_rvalid) + int'(bus.rsp_wdone) +
                         int'(bus.err_misaligned) + int'(bus.err_range);
                if (npulse != 0) begin
                    kind = bus.rsp_rvalid ? K_LOAD : bus.rsp_wdone ? K_STORE :
                           bus.err_misaligned ? K_MIS : K_RANGE;
                    if (sbq.size() == 0) begin
                        chk("unexpected_pulse", 32'(npulse), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("pulse_count", 32'(npulse), 32'd1);
                        chk("pulse_kind", 32'(kind), 32'(e.kind));
                        chk("latency", 32'(cyc), 32'(e.due));
                        if (e.kind == K_LOAD) begin
                            chk("rdata", bus.rsp_rdata, e.data);
                            chk("rd_tag", 32'(bus.rsp_rd), 32'(e.rd));
                        end else if (e.kind != K_STORE) begin
                            chk("bad_addr", bus.err_bad_addr, e.data);
                        end
                    end
                end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
                    chk("response_timeout", 32'(cyc), 32'(sbq[0].due));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t v;
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_rd       = '0;

        //            st sz    u  addr          wdata         rd kind     exp           lat
        tbl[0]  = mk(1, 2'b10, 0, 32'h0000_0FC0, 32'h7777_7777, 0, K_STORE, 32'h0,        2);
        tbl[1]  = mk(0, 2'b10, 0, 32'h0000_0FC0, 32'h0,         1, K_LOAD,  32'h7777_7777, 3);
        tbl[2]  = mk(1, 2'b10, 0, 32'h0000_0FC0, 32'h80FF_1234, 0, K_STORE, 32'h0,        2);
        tbl[3]  = mk(0, 2'b00, 0, 32'h0000_0FC3, 32'h0,         2, K_LOAD,  32'hFFFF_FF80, 3);
        tbl[4]  = mk(0, 2'b00, 1, 32'h0000_0FC3, 32'h0,         3, K_LOAD,  32'h0000_0080, 3);
        tbl[5]  = mk(0, 2'b01, 0, 32'h0000_0FC2, 32'h0,         4, K_LOAD,  32'hFFFF_80FF, 3);
        tbl[6]  = mk(0, 2'b01, 1, 32'h0000_0FC0, 32'h0,         5, K_LOAD,  32'h0000_1234, 3);
        tbl[7]  = mk(0, 2'b00, 0, 32'h0000_0FC1, 32'h0,         6, K_LOAD,  32'h0000_0012, 3);
        tbl[8]  = mk(1, 2'b10, 0, 32'h0000_0FC0, 32'h7777_7777, 0, K_STORE, 32'h0,        2);
        tbl[9]  = mk(1, 2'b00, 0, 32'h0000_0FC1, 32'hFFFF_FF33, 0, K_STORE, 32'h0,        4);
        tbl[10] = mk(0, 2'b10, 0, 32'h0000_0FC0, 32'h0,         7, K_LOAD,  32'h7777_3377, 3);
        tbl[11] = mk(1, 2'b01, 0, 32'h0000_0FC1, 32'h5555_5555, 0, K_MIS,   32'h0000_0FC1, 1);
        tbl[12] = mk(0, 2'b10, 0, 32'h0000_0FC0, 32'h0,         8, K_LOAD,  32'h7777_3377, 3);
        tbl[13] = mk(0, 2'b10, 0, 32'h0000_1000, 32'h0,         9, K_RANGE, 32'h0000_1000, 1);
        tbl[14] = mk(1, 2'b10, 0, 32'h0000_0FC2, 32'h1111_1111, 0, K_MIS,   32'h0000_0FC2, 1);
        tbl[15] = mk(0, 2'b01, 0, 32'h0000_1001, 32'h0,         9, K_RANGE, 32'h0000_1001, 1);
        tbl[16] = mk(1, 2'b01, 0, 32'h0000_0FC2, 32'h0000_ABCD, 0, K_STORE, 32'h0,        4);
        tbl[17] = mk(0, 2'b10, 0, 32'h0000_0FC0, 32'h0,        10, K_LOAD,  32'hABCD_3377, 3);
        tbl[18] = mk(1, 2'b10, 0, 32'h0000_0FC4, 32'h0,         0, K_STORE, 32'h0,        2);
        tbl[19] = mk(1, 2'b00, 0, 32'h0000_0FC4, 32'hEEEE_EE5A, 0, K_STORE, 32'h0,        2);
        tbl[20] = mk(0, 2'b10, 0, 32'h0000_0FC4, 32'h0,        11, K_LOAD,  32'h0000_005A, 3);
        tbl[21] = mk(1, 2'b10, 0, 32'h0000_0FC8, 32'hFFFF_FFFF, 0, K_STORE, 32'h0,        2);
        tbl[22] = mk(1, 2'b01, 0, 32'h0000_0FC8, 32'h0000_BEEF, 0, K_STORE, 32'h0,        2);
        tbl[23] = mk(0, 2'b10, 0, 32'h0000_0FC8, 32'h0,        12, K_LOAD,  32'hFFFF_BEEF, 3);
        tbl[24] = mk(0, 2'b01, 1, 32'h0000_0FCA, 32'h0,        13, K_LOAD,  32'h0000_FFFF, 3);
        tbl[25] = mk(0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0,        14, K_RANGE, 32'hFFFF_FFFC, 1);
        tbl[26] = mk(0, 2'b11, 0, 32'h0000_0FC8, 32'h0,        15, K_LOAD,  32'hFFFF_BEEF, 3);
        tbl[27] = mk(1, 2'b11, 0, 32'h0000_0FC6, 32'h0,         0, K_MIS,   32'h0000_0FC6, 1);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",     32'(bus.req_ready), 32'd1);
        chk("rst_rvalid",    32'(bus.rsp_rvalid), 32'd0);
        chk("rst_wdone",     32'(bus.rsp_wdone), 32'd0);
        chk("rst_rdata",     bus.rsp_rdata, 32'd0);
        chk("rst_rd",        32'(bus.rsp_rd), 32'd0);
        chk("rst_misalign",  32'(bus.err_misaligned), 32'd0);
        chk("rst_range",     32'(bus.err_range), 32'd0);
        chk("rst_bad_addr",  bus.err_bad_addr, 32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_we",        32'(bus.mem_write_enable), 32'(WE_DIS));
        chk("rst_re",        32'(bus.mem_read_enable), 32'(RE_DIS));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 28; i++) do_req(tbl[i], 1'b1);
        drain();

        // RMW cycle-by-cycle: sb 0xAB into lane 1 of 0x11223344
        do_req(mk(1, 2'b10, 0, 32'h0000_0FCC, 32'h1122_3344, 0, K_STORE, 32'h0, 2), 1'b1);
        drain();
        do_req(mk(1, 2'b00, 0, 32'h0000_0FCD, 32'h0000_00AB, 0, K_STORE, 32'h0, 4), 1'b1);
        for (int m = 1; m <= 4; m++) begin
            @(negedge clk);
            chk("rmw_ready", 32'(bus.req_ready), (m == 4) ? 32'd1 : 32'd0);
            chk("rmw_we", 32'(bus.mem_write_enable), (m == 3) ? 32'(WE_W) : 32'(WE_DIS));
            chk("rmw_re", 32'(bus.mem_read_enable), (m == 1) ? 32'(RE_W) : 32'(RE_DIS));
            if (m == 3) chk("rmw_wdata", bus.mem_wdata, 32'h1122_AB44);
        end
        do_req(mk(0, 2'b10, 0, 32'h0000_0FCC, 32'h0, 16, K_LOAD, 32'h1122_AB44, 3), 1'b1);
        drain();

        // Reset during RMW_CAP must abort the write
        v = mk(1, 2'b00, 0, 32'h0000_0FC1, 32'h0000_0011, 0, K_STORE, 32'h0, 4);
        do_req(v, 1'b0);
        exp_rd++;                       // the read phase did happen
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_we", 32'(bus.mem_write_enable), 32'(WE_DIS));
        chk("abort_re", 32'(bus.mem_read_enable), 32'(RE_DIS));
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_wdone", 32'(bus.rsp_wdone), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_we_after", 32'(bus.mem_write_enable), 32'(WE_DIS));
        end
        do_req(mk(0, 2'b10, 0, 32'h0000_0FC0, 32'h0, 17, K_LOAD, 32'hABCD_3377, 3), 1'b1);
        drain();

        chk("write_enable_cycles", 32'(wr_cyc), 32'(exp_wr));
        chk("read_enable_cycles", 32'(rd_cyc), 32'(exp_rd));
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
